rd_channel: RTL and testbench

RD_CHANNEL -- requirements
Module: rd_channel

---
 rtl/rd_channel.sv | 188 ++++++++++++++++++
 tb/tb_rd_channel.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/rd_channel.sv
// rd_channel -- read-side channel bridge between an AXI-like AR/R master
// interface and a simple synchronous memory port.
//
// Accepted read addresses are queued in a small FIFO. A four-state FSM takes
// the queue head, strobes the memory, optionally re-attempts on memory error,
// and presents one response per address, in acceptance order.
//
// Optional feature (macro RD_CHANNEL_DECERR_EN): addresses at or above
// ADDR_LIMIT are answered directly with DECERR (RRESP 11, RDATA 0) and never
// reach the memory. With the macro undefined every address goes to memory.
//
// Ports
//   clk       in   rising-edge clock
//   resetn    in   asynchronous active-low reset
//   ARVALID   in   master address valid
//   ARADDR    in   [ADDR_WIDTH] read address
//   ARREADY   out  queue can accept an address (not full)
//   RVALID    out  read response valid
//   RDATA     out  [DATA_WIDTH] read data
//   RRESP     out  [2] 00 OKAY, 10 SLVERR, 11 DECERR
//   RREADY    in   master accepts the response
//   REN       out  one-cycle memory read strobe
//   RADDROUT  out  [ADDR_WIDTH] memory read address
//   MEMDATA   in   [DATA_WIDTH] memory data, valid the cycle after REN
//   MEMERR    in   memory error, valid the cycle after REN
module rd_channel #(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned MAX_RETRY  = 2,
  parameter int unsigned ADDR_LIMIT = 24
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  ARVALID,
  input  logic [ADDR_WIDTH-1:0] ARADDR,
  output logic                  ARREADY,
  output logic                  RVALID,
  output logic [DATA_WIDTH-1:0] RDATA,
  output logic [1:0]            RRESP,
  input  logic                  RREADY,
  output logic                  REN,
  output logic [ADDR_WIDTH-1:0] RADDROUT,
  input  logic [DATA_WIDTH-1:0] MEMDATA,
  input  logic                  MEMERR
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  // Retry counter is just wide enough to reach MAX_RETRY (min 1 bit).
  localparam int unsigned RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);
  localparam logic [PW:0]   DEPTH     = (PW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t state_q, state_d;

  // Address queue
  logic [ADDR_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [PW:0]           count_q;
  logic                  full, empty, push, pop;
  logic [ADDR_WIDTH-1:0] head;

  logic [RW-1:0]         retry_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [1:0]            rresp_q;
  logic [ADDR_WIDTH-1:0] raddr_q;

  // FSM side-effect strobes
  logic addr_load, mem_load, dec_load, retry_inc, retry_clr;
  logic decerr_en, decerr_hit;

`ifdef RD_CHANNEL_DECERR_EN
  assign decerr_en = 1'b1;
`else
  assign decerr_en = 1'b0;
`endif

  assign full    = (count_q == DEPTH);
  assign empty   = (count_q == '0);
  assign head    = mem_q[rd_ptr_q];
  assign ARREADY = ~full;
  assign RVALID  = (state_q == RESP);
  assign REN     = (state_q == ISSUE);
  assign push    = ARVALID & ARREADY;
  assign pop     = RVALID & RREADY;
  assign RDATA    = rdata_q;
  assign RRESP    = rresp_q;
  assign RADDROUT = raddr_q;

  // Out-of-range decode only matters when the feature is compiled in.
  assign decerr_hit = decerr_en & (32'(head) >= 32'(ADDR_LIMIT));

  // Queue storage carries data only, so it has no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= ARADDR;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      // Simultaneous push and pop leaves occupancy unchanged.
      case ({push, pop})
        2'b10:   count_q <= count_q + (PW+1)'(1);
        2'b01:   count_q <= count_q - (PW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_load = 1'b0;
    mem_load  = 1'b0;
    dec_load  = 1'b0;
    retry_inc = 1'b0;
    retry_clr = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          if (decerr_hit) begin
            dec_load = 1'b1;
            state_d  = RESP;
          end else begin
            addr_load = 1'b1;
            state_d   = ISSUE;
          end
        end
      end
      ISSUE: begin
        state_d = WAIT;
      end
      WAIT: begin
        // RADDROUT still holds the head, so a retry just re-strobes.
        if (MEMERR && (retry_q < RETRY_MAX)) begin
          retry_inc = 1'b1;
          state_d   = ISSUE;
        end else begin
          mem_load = 1'b1;
          state_d  = RESP;
        end
      end
      RESP: begin
        if (RREADY) begin
          retry_clr = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      retry_q <= '0;
      rdata_q <= '0;
      rresp_q <= 2'b00;
      raddr_q <= '0;
    end else begin
      state_q <= state_d;
      if (retry_clr)      retry_q <= '0;
      else if (retry_inc) retry_q <= retry_q + RW'(1);
      if (addr_load) raddr_q <= head;
      if (mem_load) begin
        rdata_q <= MEMDATA;
        rresp_q <= MEMERR ? 2'b10 : 2'b00;
      end else if (dec_load) begin
        rdata_q <= '0;
        rresp_q <= 2'b11;
      end
    end
  end

endmodule

// File: tb/tb_rd_channel.sv
// Directed bench for rd_channel with a behavioural memory that returns
// memimg[addr] one cycle after REN and a per-attempt error pattern.
module tb_rd_channel;

  logic        clk = 1'b0;
  logic        resetn;
  logic        ARVALID;
  logic [4:0]  ARADDR;
  logic        ARREADY;
  logic        RVALID;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RREADY;
  logic        REN;
  logic [4:0]  RADDROUT;
  logic [31:0] MEMDATA = 32'h0;
  logic        MEMERR  = 1'b0;

  logic [31:0] memimg [32];
  logic [7:0]  err_pat = 8'h00;
  int          err_base = 0;
  int          ren_cnt = 0;
  int          n_chk = 0;
  int          n_pass = 0;
  int          base;

  rd_channel dut (
    .clk(clk), .resetn(resetn),
    .ARVALID(ARVALID), .ARADDR(ARADDR), .ARREADY(ARREADY),
    .RVALID(RVALID), .RDATA(RDATA), .RRESP(RRESP), .RREADY(RREADY),
    .REN(REN), .RADDROUT(RADDROUT), .MEMDATA(MEMDATA), .MEMERR(MEMERR)
  );

  always #5 clk = ~clk;

  // Memory model: data and error appear in the cycle after REN.
  always @(posedge clk) begin
    if (REN) begin
      ren_cnt <= ren_cnt + 1;
      MEMDATA <= memimg[RADDROUT];
      MEMERR  <= ((ren_cnt - err_base) < 8) ? err_pat[3'(ren_cnt - err_base)] : 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic wait_rv();
    int n;
    n = 0;
    while (RVALID !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("rvalid_wait", 64'(RVALID), 64'd1);
  endtask

  task automatic push_one(input logic [4:0] a);
    ARVALID = 1'b1;
    ARADDR  = a;
    tick();
    ARVALID = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) memimg[i] = 32'h1000_0000 + i;
    memimg[5] = 32'hDEAD_BEEF;
    resetn  = 1'b0;
    ARVALID = 1'b0;
    ARADDR  = 5'd0;
    RREADY  = 1'b0;
    tick();
    tick();
    chk("rst_arready", 64'(ARREADY), 64'd1);
    chk("rst_rvalid", 64'(RVALID), 64'd0);
    chk("rst_rdata", 64'(RDATA), 64'd0);
    chk("rst_rresp", 64'(RRESP), 64'd0);
    chk("rst_ren", 64'(REN), 64'd0);
    chk("rst_raddrout", 64'(RADDROUT), 64'd0);
    resetn = 1'b1;
    tick();
    chk("post_rst_ren", 64'(REN), 64'd0);

    // Single read with exact latency
    base   = ren_cnt;
    RREADY = 1'b1;
    push_one(5'd5);
    chk("t1_ren_e0", 64'(REN), 64'd0);
    tick();
    chk("t1_ren_e1", 64'(REN), 64'd1);
    chk("t1_raddrout", 64'(RADDROUT), 64'd5);
    chk("t1_rvalid_e1", 64'(RVALID), 64'd0);
    tick();
    chk("t1_ren_e2", 64'(REN), 64'd0);
    chk("t1_rvalid_e2", 64'(RVALID), 64'd0);
    tick();
    chk("t1_rvalid_e3", 64'(RVALID), 64'd1);
    chk("t1_rdata", 64'(RDATA), 64'hDEADBEEF);
    chk("t1_rresp", 64'(RRESP), 64'd0);
    tick();
    chk("t1_rvalid_done", 64'(RVALID), 64'd0);
    chk("t1_rdata_hold", 64'(RDATA), 64'hDEADBEEF);
    chk("t1_ren_count", 64'(ren_cnt - base), 64'd1);

    // Back-pressure: four addresses with the master stalled
    RREADY = 1'b0;
    base   = ren_cnt;
    for (int i = 0; i < 4; i++) begin
      chk("bp_arready_pre", 64'(ARREADY), 64'd1);
      ARVALID = 1'b1;
      ARADDR  = 5'(i + 1);
      tick();
    end
    ARVALID = 1'b0;
    chk("bp_arready_full", 64'(ARREADY), 64'd0);
    wait_rv();
    chk("bp_rdata1", 64'(RDATA), 64'h10000001);
    RREADY = 1'b1;
    tick();
    RREADY = 1'b0;
    chk("bp_arready_after_pop", 64'(ARREADY), 64'd1);
    for (int k = 2; k <= 4; k++) begin
      wait_rv();
      chk("bp_rdata_order", 64'(RDATA), 64'h10000000 + 64'(k));
      chk("bp_rresp", 64'(RRESP), 64'd0);
      RREADY = 1'b1;
      tick();
      RREADY = 1'b0;
    end
    chk("bp_ren_count", 64'(ren_cnt - base), 64'd4);

    // Retry: error, error, success
    RREADY   = 1'b1;
    base     = ren_cnt;
    err_base = ren_cnt;
    err_pat  = 8'b0000_0011;
    push_one(5'd9);
    wait_rv();
    chk("retry_rresp", 64'(RRESP), 64'd0);
    chk("retry_rdata", 64'(RDATA), 64'h10000009);
    chk("retry_ren_count", 64'(ren_cnt - base), 64'd3);
    tick();

    // Retry exhaustion: error on every attempt
    base     = ren_cnt;
    err_base = ren_cnt;
    err_pat  = 8'hFF;
    push_one(5'd10);
    wait_rv();
    chk("exh_rresp", 64'(RRESP), 64'd2);
    chk("exh_rdata", 64'(RDATA), 64'h1000000A);
    chk("exh_ren_count", 64'(ren_cnt - base), 64'd3);
    tick();
    err_pat = 8'h00;

    // Out-of-range address, then an in-range one
    base     = ren_cnt;
    err_base = ren_cnt;
    push_one(5'd30);
    wait_rv();
`ifdef RD_CHANNEL_DECERR_EN
    chk("dec_rresp", 64'(RRESP), 64'd3);
    chk("dec_rdata", 64'(RDATA), 64'd0);
    chk("dec_ren_count", 64'(ren_cnt - base), 64'd0);
`else
    chk("nodec_rresp", 64'(RRESP), 64'd0);
    chk("nodec_rdata", 64'(RDATA), 64'h1000001E);
    chk("nodec_ren_count", 64'(ren_cnt - base), 64'd1);
`endif
    tick();
    base = ren_cnt;
    push_one(5'd3);
    wait_rv();
    chk("inrange_rresp", 64'(RRESP), 64'd0);
    chk("inrange_rdata", 64'(RDATA), 64'h10000003);
    chk("inrange_ren_count", 64'(ren_cnt - base), 64'd1);
    tick();

    // Reset during WAIT with two addresses queued
    RREADY  = 1'b0;
    ARVALID = 1'b1;
    ARADDR  = 5'd6;
    tick();
    ARADDR  = 5'd7;
    tick();
    ARVALID = 1'b0;
    chk("mid_ren_issue", 64'(REN), 64'd1);
    tick();
    chk("mid_in_wait_ren", 64'(REN), 64'd0);
    resetn = 1'b0;
    #1;
    chk("mid_rst_arready", 64'(ARREADY), 64'd1);
    chk("mid_rst_rvalid", 64'(RVALID), 64'd0);
    tick();
    resetn = 1'b1;
    base   = ren_cnt;
    for (int i = 0; i < 6; i++) tick();
    chk("mid_after_arready", 64'(ARREADY), 64'd1);
    chk("mid_after_rvalid", 64'(RVALID), 64'd0);
    chk("mid_after_no_ren", 64'(ren_cnt - base), 64'd0);
    RREADY = 1'b1;
    push_one(5'd8);
    wait_rv();
    chk("mid_new_rdata", 64'(RDATA), 64'h10000008);
    chk("mid_new_ren_count", 64'(ren_cnt - base), 64'd1);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
